wb_pipe_reg: RTL

Parametrised MEM→WB pipeline register with valid/ready handshake, back-pressure, flush and an optional skid buffer. It carries the write-back record (destination register, write enable, write data, commit PC) from the memory stage to the register-file write port. Unlike the fixed-width unconditional stage register it replaces, it stalls without losing data and suppresses writes to x0. It exposes the held record for forwarding.

---
 rtl/wb_pipe_reg_if.sv | 42 ++++
 rtl/wb_pipe_reg.sv | 120 ++++++++++++
 2 files changed

// File: rtl/wb_pipe_reg_if.sv
// rtl/wb_pipe_reg_if.sv - MEM->WB write-back record bus with handshake, flush and forwarding taps
interface wb_pipe_reg_if #(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5,
    parameter int PC_W    = 64
) ();
    // Upstream (MEM stage) side
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [RADDR_W-1:0] in_rd;
    logic               in_wen;
    logic [XLEN-1:0]    in_wdata;
    logic [PC_W-1:0]    in_pc;

    // Downstream (WB stage) side
    logic               out_valid;
    logic               out_ready;
    logic [RADDR_W-1:0] out_rd;
    logic               out_wen;
    logic [XLEN-1:0]    out_wdata;
    logic [PC_W-1:0]    out_pc;

    // Forwarding taps on the held record
    logic               fwd_valid;
    logic [RADDR_W-1:0] fwd_rd;
    logic [XLEN-1:0]    fwd_data;

    // Driver of records and consumer of the pipe register outputs
    modport master (
        output flush, in_valid, in_rd, in_wen, in_wdata, in_pc, out_ready,
        input  in_ready, out_valid, out_rd, out_wen, out_wdata, out_pc,
               fwd_valid, fwd_rd, fwd_data
    );

    // The pipe register itself
    modport slave (
        input  flush, in_valid, in_rd, in_wen, in_wdata, in_pc, out_ready,
        output in_ready, out_valid, out_rd, out_wen, out_wdata, out_pc,
               fwd_valid, fwd_rd, fwd_data
    );
endinterface

// File: rtl/wb_pipe_reg.sv
// rtl/wb_pipe_reg.sv - MEM->WB pipeline register with back-pressure, flush, x0 suppression and optional skid entry
module wb_pipe_reg #(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5,
    parameter int PC_W    = 64,
    parameter int SKID    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_pipe_reg_if.slave  bus
);
    localparam bit USE_SKID = (SKID != 0);

    // Main entry M drives the outputs; skid entry S absorbs one record while M is stalled
    logic               m_valid;
    logic [RADDR_W-1:0] m_rd;
    logic               m_wen;
    logic [XLEN-1:0]    m_wdata;
    logic [PC_W-1:0]    m_pc;

    logic               s_valid;
    logic [RADDR_W-1:0] s_rd;
    logic               s_wen;
    logic [XLEN-1:0]    s_wdata;
    logic [PC_W-1:0]    s_pc;

    logic in_ready_i;
    logic in_xfer;
    logic m_take;
    logic s_fill;
    logic cap_wen;

    // Handshake decode: M may take a new record when empty or being consumed; S only fills behind a stalled M
    always_comb begin
        in_ready_i = 1'b0;
        in_xfer    = 1'b0;
        m_take     = 1'b0;
        s_fill     = 1'b0;
        cap_wen    = 1'b0;
        if (USE_SKID) begin
            in_ready_i = ~s_valid;
        end else begin
            in_ready_i = ~m_valid | bus.out_ready;
        end
        in_xfer = bus.in_valid & in_ready_i;
        m_take  = ~m_valid | bus.out_ready;
        s_fill  = USE_SKID & m_valid & ~bus.out_ready & in_xfer;
        // Writes to x0 are dropped at capture so they never reach the register file or forwarding
        cap_wen = bus.in_wen & (bus.in_rd != '0);
    end

    // Valid bits: reset and flush clear both entries; S drains into M ahead of any new input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else begin
            if (m_take) begin
                m_valid <= s_valid | in_xfer;
            end
            if (s_fill) begin
                s_valid <= 1'b1;
            end else if (m_take) begin
                s_valid <= 1'b0;
            end
        end
    end

    // Main payload: loads from S when it holds a record, otherwise from the input; flush leaves it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rd    <= '0;
            m_wen   <= 1'b0;
            m_wdata <= '0;
            m_pc    <= '0;
        end else if (m_take) begin
            if (s_valid) begin
                m_rd    <= s_rd;
                m_wen   <= s_wen;
                m_wdata <= s_wdata;
                m_pc    <= s_pc;
            end else if (in_xfer) begin
                m_rd    <= bus.in_rd;
                m_wen   <= cap_wen;
                m_wdata <= bus.in_wdata;
                m_pc    <= bus.in_pc;
            end
        end
    end

    // Skid payload: captures the input that arrives while M is full and stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_rd    <= '0;
            s_wen   <= 1'b0;
            s_wdata <= '0;
            s_pc    <= '0;
        end else if (s_fill) begin
            s_rd    <= bus.in_rd;
            s_wen   <= cap_wen;
            s_wdata <= bus.in_wdata;
            s_pc    <= bus.in_pc;
        end
    end

    // Outputs: write enable is gated by valid so a stale payload can never commit
    assign bus.in_ready  = in_ready_i;
    assign bus.out_valid = m_valid;
    assign bus.out_rd    = m_rd;
    assign bus.out_wen   = m_wen & m_valid;
    assign bus.out_wdata = m_wdata;
    assign bus.out_pc    = m_pc;
    assign bus.fwd_valid = m_wen & m_valid;
    assign bus.fwd_rd    = m_rd;
    assign bus.fwd_data  = m_wdata;

endmodule
